iter_alu: RTL and testbench

Parametrised multi-cycle ALU for the single-cycle RISC-V core's successor datapath: same opcode space as the combinational ALU, widened to WIDTH bits, with variable shift amounts, an iterative multiplier and an optional iterative divider. Operations are issued with a valid/ready handshake and results are returned with a valid/ready handshake, so the block sits between decode/operand-read and writeback of a stalling pipeline.

---
 rtl/iter_alu.sv | 212 +++++++++++++++++++++
 tb/tb_iter_alu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// ---------------------------------------------------------------------------
// iter_alu -- multi-cycle ALU with valid/ready handshakes on both sides.
//
// Single-cycle class (ADD/SUB/AND/OR/XOR/SLT/SLTU/undefined) completes on the
// accept edge. Shifts move one bit per cycle, MUL is shift-add over WIDTH
// cycles, and the optional restoring divider produces one quotient bit per
// cycle over WIDTH cycles.
//
// Build option: define ALU_DIV_EN to include the divider (opcodes 1100 DIVU,
// 1101 REMU). Without it those opcodes return 0 like undefined opcodes.
//
// Ports:
//   clk         rising-edge clock
//   rstN        asynchronous active-low reset
//   inValid     operation request
//   inReady     request accepted this cycle when high (IDLE only)
//   operandA    first operand
//   operandB    second operand / shift amount (low SHW bits)
//   aluControl  opcode
//   outValid    result available (DONE)
//   outReady    consumer accepts result
//   result      registered result, stable while outValid
//   busy        any state other than IDLE
// ---------------------------------------------------------------------------
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [3:0]       aluControl,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  // Counter must hold WIDTH itself, hence one bit more than the shift amount.
  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;  // shift register / accumulator / remainder while iterating
  logic [WIDTH-1:0] a_q, a_d;            // multiplicand (MUL) or dividend->quotient (DIV)
  logic [WIDTH-1:0] b_q, b_d;            // multiplier (MUL) or divisor (DIV)
  logic [CW-1:0]    cnt_q, cnt_d;        // remaining iterations
  logic [3:0]       op_q, op_d;

  logic [SHW-1:0]   shamt;
  assign shamt = operandB[SHW-1:0];

`ifdef ALU_DIV_EN
  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor if it fits. A zero divisor always
  // "fits", which yields an all-ones quotient and remainder = dividend.
  logic [WIDTH:0]   rem_sh, trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next, q_next;

  always_comb begin
    rem_sh   = {result_q, a_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, b_q};
    q_bit    = rem_sh[WIDTH] | ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_next   = {a_q[WIDTH-2:0], q_bit};
  end
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    op_d     = op_q;

    case (state_q)
      S_IDLE: begin
        if (inValid) begin
          op_d    = aluControl;
          a_d     = operandA;
          b_d     = operandB;
          cnt_d   = '0;
          state_d = S_DONE;
          case (aluControl)
            OP_ADD:  result_d = operandA + operandB;
            OP_SUB:  result_d = operandA - operandB;
            OP_AND:  result_d = operandA & operandB;
            OP_OR:   result_d = operandA | operandB;
            OP_XOR:  result_d = operandA ^ operandB;
            OP_SLT:  result_d = WIDTH'($signed(operandA) < $signed(operandB));
            OP_SLTU: result_d = WIDTH'(operandA < operandB);
            OP_SLL, OP_SRL, OP_SRA: begin
              result_d = operandA;
              // A zero shift amount is already finished.
              if (shamt != '0) begin
                cnt_d   = CW'(shamt);
                state_d = S_SHIFT;
              end
            end
            OP_MUL: begin
              result_d = '0;
              cnt_d    = CW'(WIDTH);
              state_d  = S_MUL;
            end
`ifdef ALU_DIV_EN
            OP_DIVU, OP_REMU: begin
              result_d = '0;
              cnt_d    = CW'(WIDTH);
              state_d  = S_DIV;
            end
`endif
            default: result_d = '0;
          endcase
        end
      end

      S_SHIFT: begin
        case (op_q)
          OP_SLL:  result_d = {result_q[WIDTH-2:0], 1'b0};
          OP_SRL:  result_d = {1'b0, result_q[WIDTH-1:1]};
          default: result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
        endcase
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end

      S_MUL: begin
        result_d = result_q + (b_q[0] ? a_q : '0);
        a_d      = {a_q[WIDTH-2:0], 1'b0};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end

`ifdef ALU_DIV_EN
      S_DIV: begin
        a_d      = q_next;
        result_d = rem_next;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last step: present the quotient or the remainder.
          result_d = (op_q == OP_REMU) ? rem_next : q_next;
          state_d  = S_DONE;
        end
      end
`endif

      S_DONE: begin
        if (outReady) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every flop, datapath included, is reset so that result reads 0
  // after reset and an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  assign inReady  = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign outValid = (state_q == S_DONE);
  assign result   = result_q;

endmodule

// File: tb/tb_iter_alu.sv
// ---------------------------------------------------------------------------
// tb_iter_alu -- self-checking bench for iter_alu (WIDTH = 32).
// Table-driven vectors plus a few hand-written sequences (reset mid-MUL,
// backpressure). Expected results are pushed to a scoreboard queue when an
// operation is issued and popped when the DUT raises outValid.
// Honours ALU_DIV_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_iter_alu;

  localparam int W = 32;

`ifdef ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic         clk;
  logic         rstN;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] operandA;
  logic [W-1:0] operandB;
  logic [3:0]   aluControl;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] result;
  logic         busy;

  iter_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .inValid    (inValid),
    .inReady    (inReady),
    .operandA   (operandA),
    .operandB   (operandB),
    .aluControl (aluControl),
    .outValid   (outValid),
    .outReady   (outReady),
    .result     (result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference used for the random vectors.
  function automatic logic [W-1:0] model_res(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [63:0] p;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return W'($signed(a) >>> b[4:0]);
      4'd8:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd9:  return (a < b) ? 1 : 0;
      4'd10: begin p = 64'(a) * 64'(b); return p[W-1:0]; end
      4'd12: return !DIV_ON ? '0 : (b == 0) ? '1 : a / b;
      4'd13: return !DIV_ON ? '0 : (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] b);
    case (op)
      4'd5, 4'd6, 4'd7: return 1 + int'(b[4:0]);
      4'd10:            return W + 1;
      4'd12, 4'd13:     return DIV_ON ? W + 1 : 1;
      default:          return 1;
    endcase
  endfunction

  // Called at a negedge. Waits for inReady, drives one request, pushes the
  // expectation, then scrambles the inputs to prove they were latched.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input int lat, input bit track);
    int w = 0;
    while (!inReady && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!inReady) check("issue_ready_timeout", {63'd0, inReady}, 64'd1);
    inValid    = 1'b1;
    aluControl = op;
    operandA   = a;
    operandB   = b;
    if (track) sb.push_back('{res: res, lat: lat});
    @(posedge clk);
    #1;
    inValid    = 1'b0;
    operandA   = $urandom();
    operandB   = $urandom();
    aluControl = 4'($urandom_range(0, 15));
  endtask

  // Called right after issue; measures latency to outValid and compares.
  task automatic wait_result(input string name);
    exp_t e;
    int   lat;
    e = sb.pop_front();
    lat = 0;
    while (lat <= 200) begin
      @(negedge clk);
      lat++;
      if (outValid) break;
    end
    check({name, "_res"}, 64'(result), 64'(e.res));
    check({name, "_lat"}, 64'(lat), 64'(e.lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1};  // SUB wrap
    vecs[1]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};  // SLT
    vecs[2]  = '{4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};  // SLTU
    vecs[3]  = '{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1};  // undefined
    vecs[4]  = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1};  // ADD wrap
    vecs[5]  = '{4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1};  // AND
    vecs[6]  = '{4'b0011, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1};  // OR
    vecs[7]  = '{4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1};  // XOR
    vecs[8]  = '{4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5};  // SRA
    vecs[9]  = '{4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32}; // SLL 31
    vecs[10] = '{4'b0110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1};  // SRL 0
    vecs[11] = '{4'b0110, 32'h8000_0000, 32'h0000_0025, 32'h0400_0000, 6};  // shamt 5 of 0x25
    vecs[12] = '{4'b0101, 32'hCAFE_BABE, 32'h0000_0020, 32'hCAFE_BABE, 1};  // shamt 0 of 0x20
    vecs[13] = '{4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33}; // MUL wrap
    vecs[14] = '{4'b1010, 32'd12345,     32'h0000_0000, 32'h0000_0000, 33}; // MUL by 0
    vecs[15] = '{4'b1010, 32'd7,         32'd9,         32'd63,        33};
    vecs[16] = '{4'b1100, 32'd100, 32'd7, DIV_ON ? 32'd14 : 32'd0, DIV_ON ? 33 : 1};
    vecs[17] = '{4'b1101, 32'd100, 32'd7, DIV_ON ? 32'd2 : 32'd0,  DIV_ON ? 33 : 1};
    vecs[18] = '{4'b1100, 32'h0000_DEAD, 32'd0, DIV_ON ? 32'hFFFF_FFFF : 32'd0, DIV_ON ? 33 : 1};
    vecs[19] = '{4'b1101, 32'd55, 32'd0, DIV_ON ? 32'd55 : 32'd0, DIV_ON ? 33 : 1};
    vecs[20] = '{4'b1100, 32'hFFFF_FFFF, 32'h10, DIV_ON ? 32'h0FFF_FFFF : 32'd0, DIV_ON ? 33 : 1};
    vecs[21] = '{4'b1101, 32'hFFFF_FFFF, 32'h10, DIV_ON ? 32'h0000_000F : 32'd0, DIV_ON ? 33 : 1};

    rstN       = 1'b0;
    inValid    = 1'b0;
    operandA   = '0;
    operandB   = '0;
    aluControl = '0;
    outReady   = 1'b1;

    // Reset state.
    #12;
    check("rst_outValid", {63'd0, outValid}, 64'd0);
    check("rst_busy",     {63'd0, busy},     64'd0);
    check("rst_result",   64'(result),       64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check("rst_inReady", {63'd0, inReady}, 64'd1);

    // Table vectors.
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b1);
      wait_result($sformatf("vec%0d", i));
    end

    // Random vectors against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = (op == 4'd12 || op == 4'd13) ? W'($urandom_range(0, 1000)) : $urandom();
      issue(op, a, b, model_res(op, a, b), model_lat(op, b), 1'b1);
      wait_result($sformatf("rnd%0d_op%0d", i, op));
    end

    // Reset in the middle of a MUL: result is discarded.
    issue(4'b1010, 32'd7, 32'd9, '0, 0, 1'b0);
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("midrst_outValid", {63'd0, outValid}, 64'd0);
    check("midrst_busy",     {63'd0, busy},     64'd0);
    check("midrst_result",   64'(result),       64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check("midrst_inReady", {63'd0, inReady}, 64'd1);
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (outValid || busy) seen++;
      end
      check("midrst_no_output", 64'(seen), 64'd0);
    end
    issue(4'b0000, 32'd2, 32'd3, 32'd5, 1, 1'b1);
    wait_result("post_rst_add");

    // Backpressure: consumer stalls for 10 cycles.
    @(negedge clk);
    outReady = 1'b0;
    issue(4'b0000, 32'd1, 32'd1, 32'd2, 1, 1'b1);
    wait_result("bp_add");
    begin
      int bad = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (outValid !== 1'b1 || result !== 32'd2 || inReady !== 1'b0) bad++;
      end
      check("bp_stable", 64'(bad), 64'd0);
    end
    outReady = 1'b1;
    @(negedge clk);
    check("bp_outValid_drop", {63'd0, outValid}, 64'd0);
    check("bp_inReady_back",  {63'd0, inReady},  64'd1);
    issue(4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1, 1'b1);
    check("bp_next_accepted", {63'd0, busy}, 64'd1);
    wait_result("bp_next");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
